// File: rtl/seq0237_checker.sv
// -----------------------------------------------------------------------------
// seq0237_checker
//
// Purpose:
//   Watches the 3-bit count bus of the 0-2-3-7 sequence FSM. It locks onto the
//   cyclic sequence 0 -> 2 -> 3 -> 7 -> 0 and then flags every deviation. It
//   also keeps saturating error and completed-cycle statistics.
//
// Optional feature (macro SEQ_CHK_CAPTURE_EN):
//   When defined, err_exp/err_got hold the expected and received code of the
//   first error since reset or the last clr_err. When undefined, those ports
//   and their registers do not exist.
//
// Parameters:
//   LOCK_LEN  consecutive correct transitions needed to reach LOCKED (>= 1)
//   ERR_W     width of err_cnt
//   WRAP_W    width of wrap_cnt
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   count_in    count value sampled from the sequence FSM
//   valid_in    count_in carries a new sample this cycle
//   clr_err     synchronous clear of err_sticky / err_cnt (a same-cycle error wins)
//   locked      1 while in LOCKED
//   err_pulse   one-cycle pulse per detected sequence error
//   err_sticky  set on any error, cleared by reset or clr_err
//   err_cnt     saturating error count
//   wrap_cnt    saturating count of 7->0 transitions seen while LOCKED
//   state_dbg   current FSM state (HUNT=0, SYNC=1, LOCKED=2)
//   err_exp     (optional) expected code of the first captured error
//   err_got     (optional) received code of the first captured error
//
// Handshake: valid_in is a valid-only qualifier with no back-pressure. A
// sample is consumed on every rising edge where valid_in=1. When valid_in=0,
// the FSM, prev, counters and flags hold and err_pulse is 0.
// -----------------------------------------------------------------------------
module seq0237_checker #(
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        count_in,
    input  logic              valid_in,
    input  logic              clr_err,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [1:0]        state_dbg
`ifdef SEQ_CHK_CAPTURE_EN
    ,
    output logic [2:0]        err_exp,
    output logic [2:0]        err_got
`endif
);

    // match_cnt must be able to hold LOCK_LEN itself.
    localparam int MW = $clog2(LOCK_LEN + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    logic [2:0]    prev;
    logic [MW-1:0] match_cnt;

    logic          legal;
    logic [2:0]    exp_code;
    logic          hit;
    logic          sync_done;
    logic          err_det;
    logic          wrap_hit;

    assign state_dbg = state;

    // Sample classification against the successor of the last accepted code.
    always_comb begin
        legal     = 1'b0;
        exp_code  = 3'd0;
        case (count_in)
            3'd0, 3'd2, 3'd3, 3'd7: legal = 1'b1;
            default:                legal = 1'b0;
        endcase
        case (prev)
            3'd0:    exp_code = 3'd2;
            3'd2:    exp_code = 3'd3;
            3'd3:    exp_code = 3'd7;
            3'd7:    exp_code = 3'd0;
            default: exp_code = 3'd0;
        endcase
        hit       = (count_in == exp_code);
        // This SYNC hit is the LOCK_LEN-th consecutive correct transition.
        sync_done = ((int'(match_cnt) + 1) >= LOCK_LEN);
        // Only LOCKED reports errors. Repeated values are mismatches as well.
        err_det   = valid_in && (state == LOCKED) && !hit;
        // A hit from prev=7 is by construction the 7->0 wrap.
        wrap_hit  = valid_in && (state == LOCKED) && hit && (prev == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= HUNT;
            prev       <= 3'd0;
            match_cnt  <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
`ifdef SEQ_CHK_CAPTURE_EN
            err_exp    <= 3'd0;
            err_got    <= 3'd0;
`endif
        end else begin
            err_pulse <= err_det;

            // Error statistics. A same-cycle error overrides clr_err, so the
            // clear and the new error together leave a count of one.
            if (err_det) begin
                err_sticky <= 1'b1;
                if (clr_err) begin
                    err_cnt <= ERR_W'(1);
                end else if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end else if (clr_err) begin
                err_sticky <= 1'b0;
                err_cnt    <= '0;
            end

`ifdef SEQ_CHK_CAPTURE_EN
            // Capture only the first error. It stays frozen while err_sticky
            // is set, unless clr_err opens a new capture window this cycle.
            if (err_det && (!err_sticky || clr_err)) begin
                err_exp <= exp_code;
                err_got <= count_in;
            end else if (clr_err && !err_det) begin
                err_exp <= 3'd0;
                err_got <= 3'd0;
            end
`endif

            // wrap_cnt ignores clr_err; only reset clears it.
            if (wrap_hit && (wrap_cnt != '1)) begin
                wrap_cnt <= wrap_cnt + 1'b1;
            end

            if (valid_in) begin
                case (state)
                    HUNT: begin
                        // Illegal codes are silently skipped while hunting.
                        if (legal) begin
                            prev      <= count_in;
                            match_cnt <= '0;
                            state     <= SYNC;
                        end
                    end

                    SYNC: begin
                        if (hit) begin
                            prev      <= count_in;
                            match_cnt <= match_cnt + 1'b1;
                            if (sync_done) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (legal) begin
                            // Restart the run from this legal code.
                            prev      <= count_in;
                            match_cnt <= '0;
                        end else begin
                            state <= HUNT;
                        end
                    end

                    LOCKED: begin
                        if (hit) begin
                            prev <= count_in;
                        end else begin
                            locked <= 1'b0;
                            if (legal) begin
                                // The offending legal code is the first
                                // sample of a new SYNC run.
                                prev      <= count_in;
                                match_cnt <= '0;
                                state     <= SYNC;
                            end else begin
                                state <= HUNT;
                            end
                        end
                    end

                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq0237_checker.sv
// -----------------------------------------------------------------------------
// tb_seq0237_checker
//
// Directed bench for seq0237_checker. The DUT is built with ERR_W=2 so that
// error-counter saturation is reachable in a few vectors. LOCK_LEN=4 and
// WRAP_W=8 keep their default values. Expected values are hand-computed from
// the behaviour of the 0-2-3-7 lock/check FSM.
// -----------------------------------------------------------------------------
module tb_seq0237_checker;

    localparam int LOCK_LEN = 4;
    localparam int ERR_W    = 2;
    localparam int WRAP_W   = 8;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic              clk;
    logic              rst;
    logic [2:0]        count_in;
    logic              valid_in;
    logic              clr_err;
    logic              locked;
    logic              err_pulse;
    logic              err_sticky;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [1:0]        state_dbg;
`ifdef SEQ_CHK_CAPTURE_EN
    logic [2:0]        err_exp;
    logic [2:0]        err_got;
`endif

    int n_vec;
    int n_err;

    // Expected locked flag for each sample of the first lock-up sequence.
    logic [0:0] exp_q[$];

    seq0237_checker #(
        .LOCK_LEN (LOCK_LEN),
        .ERR_W    (ERR_W),
        .WRAP_W   (WRAP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .valid_in   (valid_in),
        .clr_err    (clr_err),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .wrap_cnt   (wrap_cnt),
        .state_dbg  (state_dbg)
`ifdef SEQ_CHK_CAPTURE_EN
        ,
        .err_exp    (err_exp),
        .err_got    (err_got)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic lk, input logic pl,
                             input logic st, input int ec, input int wc);
        check({tag, ".locked"},     32'(locked),     32'(lk));
        check({tag, ".err_pulse"},  32'(err_pulse),  32'(pl));
        check({tag, ".err_sticky"}, 32'(err_sticky), 32'(st));
        check({tag, ".err_cnt"},    32'(err_cnt),    32'(ec));
        check({tag, ".wrap_cnt"},   32'(wrap_cnt),   32'(wc));
    endtask

    // ---------------- driver ----------------
    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic [2:0] c, input logic v, input logic clr);
        count_in = c;
        valid_in = v;
        clr_err  = clr;
        @(posedge clk);
        #1;
    endtask

    // Drives 2,3,7,0 from a SYNC state with prev=0 and match_cnt=0.
    task automatic relock_from_0();
        step(3'd2, 1'b1, 1'b0);
        step(3'd3, 1'b1, 1'b0);
        step(3'd7, 1'b1, 1'b0);
        step(3'd0, 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] seq1 [0:8];
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b0;
        count_in = 3'd0;
        valid_in = 1'b0;
        clr_err  = 1'b0;
        seq1 = '{3'd0, 3'd2, 3'd3, 3'd7, 3'd0, 3'd2, 3'd3, 3'd7, 3'd0};

        // Reset state, with valid_in asserted to show that reset overrides it.
        step(3'd2, 1'b1, 1'b1);
        step(3'd2, 1'b1, 1'b0);
        check_all("reset", 1'b0, 1'b0, 1'b0, 0, 0);
        check("reset.state", 32'(state_dbg), 32'(ST_HUNT));
        rst = 1'b1;

        // Illegal codes in HUNT are ignored and produce no error.
        step(3'd1, 1'b1, 1'b0);
        step(3'd4, 1'b1, 1'b0);
        check_all("hunt_illegal", 1'b0, 1'b0, 1'b0, 0, 0);
        check("hunt_illegal.state", 32'(state_dbg), 32'(ST_HUNT));

        // Test 1: lock-up, then one full cycle.
        for (int i = 0; i < 9; i++) exp_q.push_back((i >= 4) ? 1'b1 : 1'b0);
        for (int i = 0; i < 9; i++) begin
            logic [0:0] e;
            step(seq1[i], 1'b1, 1'b0);
            e = exp_q.pop_front();
            check($sformatf("lock.s%0d.locked", i), 32'(locked), 32'(e));
        end
        check_all("lock_done", 1'b1, 1'b0, 1'b0, 0, 1);

        // Test 2: illegal code while LOCKED with prev=0.
        step(3'd5, 1'b1, 1'b0);
        check_all("err_illegal", 1'b0, 1'b1, 1'b1, 1, 1);
        check("err_illegal.state", 32'(state_dbg), 32'(ST_HUNT));
`ifdef SEQ_CHK_CAPTURE_EN
        check("err_illegal.err_exp", 32'(err_exp), 32'd2);
        check("err_illegal.err_got", 32'(err_got), 32'd5);
`endif
        step(3'd5, 1'b0, 1'b0);
        check("err_illegal.pulse_off", 32'(err_pulse), 32'd0);
        step(3'd0, 1'b1, 1'b0);
        check("relock1.state", 32'(state_dbg), 32'(ST_SYNC));
        relock_from_0();
        check_all("relock1", 1'b1, 1'b0, 1'b1, 1, 1);

        // Test 3: stall at 3, then 7 with valid_in=1.
        step(3'd2, 1'b1, 1'b0);
        step(3'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(3'd3, 1'b0, 1'b0);
            check($sformatf("stall%0d.locked", i), 32'(locked), 32'd1);
            check($sformatf("stall%0d.pulse", i), 32'(err_pulse), 32'd0);
        end
        step(3'd7, 1'b1, 1'b0);
        check_all("after_stall", 1'b1, 1'b0, 1'b1, 1, 1);
        step(3'd0, 1'b1, 1'b0);
        check("wrap2", 32'(wrap_cnt), 32'd2);

        // Test 4: five repeat-value errors, each followed by a relock. The
        // 2-bit err_cnt saturates at 3.
        for (int k = 0; k < 5; k++) begin
            step(3'd0, 1'b1, 1'b0);
            check($sformatf("sat%0d.err_cnt", k), 32'(err_cnt), 32'((k + 2 > 3) ? 3 : k + 2));
            check($sformatf("sat%0d.pulse", k), 32'(err_pulse), 32'd1);
            relock_from_0();
            check($sformatf("sat%0d.locked", k), 32'(locked), 32'd1);
        end
        check_all("sat_done", 1'b1, 1'b0, 1'b1, 3, 2);
`ifdef SEQ_CHK_CAPTURE_EN
        check("sat.err_exp_frozen", 32'(err_exp), 32'd2);
        check("sat.err_got_frozen", 32'(err_got), 32'd5);
`endif

        // Test 5: clr_err coinciding with a mismatch (7 when 2 is expected).
        step(3'd7, 1'b1, 1'b1);
        check_all("clr_with_err", 1'b0, 1'b1, 1'b1, 1, 2);
`ifdef SEQ_CHK_CAPTURE_EN
        check("clr_with_err.err_exp", 32'(err_exp), 32'd2);
        check("clr_with_err.err_got", 32'(err_got), 32'd7);
`endif
        step(3'd0, 1'b1, 1'b0);
        step(3'd2, 1'b1, 1'b0);
        step(3'd3, 1'b1, 1'b0);
        step(3'd7, 1'b1, 1'b0);
        check("relock7.locked", 32'(locked), 32'd1);
        step(3'd0, 1'b1, 1'b0);
        check("wrap3", 32'(wrap_cnt), 32'd3);
        step(3'd2, 1'b1, 1'b1);
        check_all("clr_alone", 1'b1, 1'b0, 1'b0, 0, 3);
`ifdef SEQ_CHK_CAPTURE_EN
        check("clr_alone.err_exp", 32'(err_exp), 32'd0);
        check("clr_alone.err_got", 32'(err_got), 32'd0);
`endif

        // Test 6: build err_cnt=2 while locked, then reset for one edge.
        step(3'd2, 1'b1, 1'b0);
        step(3'd3, 1'b1, 1'b0);
        step(3'd7, 1'b1, 1'b0);
        step(3'd0, 1'b1, 1'b0);
        step(3'd2, 1'b1, 1'b0);
        step(3'd7, 1'b1, 1'b0);
        step(3'd0, 1'b1, 1'b0);
        step(3'd2, 1'b1, 1'b0);
        step(3'd3, 1'b1, 1'b0);
        step(3'd7, 1'b1, 1'b0);
        check_all("pre_reset", 1'b1, 1'b0, 1'b1, 2, 3);
        rst = 1'b0;
        step(3'd0, 1'b1, 1'b0);
        rst = 1'b1;
        check_all("mid_reset", 1'b0, 1'b0, 1'b0, 0, 0);
        check("mid_reset.state", 32'(state_dbg), 32'(ST_HUNT));
`ifdef SEQ_CHK_CAPTURE_EN
        check("mid_reset.err_exp", 32'(err_exp), 32'd0);
        check("mid_reset.err_got", 32'(err_got), 32'd0);
`endif
        step(3'd0, 1'b1, 1'b0);
        step(3'd2, 1'b1, 1'b0);
        step(3'd3, 1'b1, 1'b0);
        step(3'd7, 1'b1, 1'b0);
        check("post_reset.not_yet", 32'(locked), 32'd0);
        step(3'd0, 1'b1, 1'b0);
        check_all("post_reset.relock", 1'b1, 1'b0, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
